// File: rtl/mc_control.sv
// tiny5 multicycle controller: fetch/decode/execute/mem sequencing with a ready
// handshake, bus timeout and a sticky TRAP state for illegal instructions or bus errors.
package mc_pkg;
    typedef enum logic {MEM_ADDR_PC, MEM_ADDR_ALU_OUT} mem_rd_addr_sel_t;
    typedef enum logic {NEXT_PC_PC_4, NEXT_PC_ALU_OUT} next_pc_sel_t;
    typedef enum logic [1:0] {RF_IN_ALU_OUT, RF_IN_PC_4, RF_IN_MEM_RD_DATA} regfile_in_sel_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
    typedef enum logic [1:0] {IN1_PC, IN1_REGFILE_OUT1, IN1_ZERO} alu_in1_sel_t;
    typedef enum logic [2:0] {
        IN2_REGFILE_OUT2, IN2_ITYPE_IMM, IN2_UTYPE_IMM,
        IN2_JTYPE_IMM, IN2_STYPE_IMM, IN2_BTYPE_IMM
    } alu_in2_sel_t;
endpackage

module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 16,
    parameter bit          SUPPORT_LOADSTORE = 1'b1,
    parameter bit          SUPPORT_BRANCH    = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [31:0]      ir_i,
    input  logic             mem_ready_i,
    input  logic             br_taken_i,
    output logic             pc_we_o,
    output logic             ir_we_o,
    output logic             regfile_we_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [1:0]       mem_size_o,
    output logic             mem_unsigned_o,
    output mem_rd_addr_sel_t mem_addr_sel_o,
    output next_pc_sel_t     next_pc_sel_o,
    output regfile_in_sel_t  regfile_in_sel_o,
    output alu_op_t          alu_op_o,
    output alu_in1_sel_t     alu_in1_sel_o,
    output alu_in2_sel_t     alu_in2_sel_o,
    output logic [2:0]       cmp_op_o,
    output logic             illegal_instr_o,
    output logic             bus_error_o,
    output logic             halted_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {RESET, FETCH, DECODE, EXEC, MEM, TRAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          illegal_q, bus_err_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_store, illegal, mem_wait, timeout_hit;
    logic       unused_ir;

    assign opcode    = ir_i[6:0];
    assign funct3    = ir_i[14:12];
    assign funct7    = ir_i[31:25];
    assign is_store  = (opcode == OPC_STORE);
    assign unused_ir = ^{ir_i[24:15], ir_i[11:7]};

    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM: illegal = 1'b0;
            OPC_BRANCH: illegal = !SUPPORT_BRANCH || (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_LOAD:   illegal = !SUPPORT_LOADSTORE || (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OPC_STORE:  illegal = !SUPPORT_LOADSTORE || (funct3 > 3'b010);
            // funct7=0x20 only selects SUB and SRA
            OPC_OP:     illegal = !((funct7 == 7'h00) ||
                                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            default:    illegal = 1'b1;
        endcase
    end

    assign mem_wait    = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_wait && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= RESET;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((TIMEOUT_CYCLES != 0) && mem_wait && (state_d == state_q)) cnt_q <= cnt_q + 1'b1;
            else                                                           cnt_q <= '0;
            if ((state_q == DECODE) && illegal) illegal_q <= 1'b1;
            if (timeout_hit)                    bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_we_o          = 1'b0;
        ir_we_o          = 1'b0;
        regfile_we_o     = 1'b0;
        mem_req_o        = 1'b0;
        mem_we_o         = 1'b0;
        mem_size_o       = 2'b00;
        mem_unsigned_o   = 1'b0;
        mem_addr_sel_o   = MEM_ADDR_PC;
        next_pc_sel_o    = NEXT_PC_PC_4;
        regfile_in_sel_o = RF_IN_ALU_OUT;
        alu_op_o         = ALU_ADD;
        alu_in1_sel_o    = IN1_PC;
        alu_in2_sel_o    = IN2_REGFILE_OUT2;
        cmp_op_o         = 3'b000;
        case (state_q)
            RESET: state_d = FETCH;
            FETCH: begin
                mem_req_o  = 1'b1;
                mem_size_o = 2'b10;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                end
            end
            DECODE: state_d = illegal ? TRAP : EXEC;
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OPC_LUI: begin
                        alu_in1_sel_o = IN1_ZERO;
                        alu_in2_sel_o = IN2_UTYPE_IMM;
                        regfile_we_o  = 1'b1;
                        pc_we_o       = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_in2_sel_o = IN2_UTYPE_IMM;
                        regfile_we_o  = 1'b1;
                        pc_we_o       = 1'b1;
                    end
                    OPC_JAL, OPC_JALR: begin
                        alu_in1_sel_o    = (opcode == OPC_JAL) ? IN1_PC : IN1_REGFILE_OUT1;
                        alu_in2_sel_o    = (opcode == OPC_JAL) ? IN2_JTYPE_IMM : IN2_ITYPE_IMM;
                        next_pc_sel_o    = NEXT_PC_ALU_OUT;
                        regfile_in_sel_o = RF_IN_PC_4;
                        regfile_we_o     = 1'b1;
                        pc_we_o          = 1'b1;
                    end
                    OPC_OP_IMM: begin
                        alu_in1_sel_o = IN1_REGFILE_OUT1;
                        alu_in2_sel_o = IN2_ITYPE_IMM;
                        alu_op_o      = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
                        regfile_we_o  = 1'b1;
                        pc_we_o       = 1'b1;
                    end
                    OPC_OP: begin
                        alu_in1_sel_o = IN1_REGFILE_OUT1;
                        alu_op_o      = alu_decode(funct3, funct7[5]);
                        regfile_we_o  = 1'b1;
                        pc_we_o       = 1'b1;
                    end
                    OPC_BRANCH: begin
                        alu_in2_sel_o = IN2_BTYPE_IMM;
                        cmp_op_o      = funct3;
                        next_pc_sel_o = br_taken_i ? NEXT_PC_ALU_OUT : NEXT_PC_PC_4;
                        pc_we_o       = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_in1_sel_o = IN1_REGFILE_OUT1;
                        alu_in2_sel_o = is_store ? IN2_STYPE_IMM : IN2_ITYPE_IMM;
                        state_d       = MEM;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                // keep the address computation alive so ALU_OUT stays valid through waits
                alu_in1_sel_o  = IN1_REGFILE_OUT1;
                alu_in2_sel_o  = is_store ? IN2_STYPE_IMM : IN2_ITYPE_IMM;
                mem_req_o      = 1'b1;
                mem_addr_sel_o = MEM_ADDR_ALU_OUT;
                mem_we_o       = is_store;
                mem_size_o     = funct3[1:0];
                mem_unsigned_o = !is_store && funct3[2];
                if (mem_ready_i) begin
                    pc_we_o = 1'b1;
                    if (!is_store) begin
                        regfile_we_o     = 1'b1;
                        regfile_in_sel_o = RF_IN_MEM_RD_DATA;
                    end
                    state_d = FETCH;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = RESET;
        endcase
    end

    assign illegal_instr_o = illegal_q;
    assign bus_error_o     = bus_err_q;
    assign halted_o        = (state_q == TRAP);
endmodule
